uart_param: RTL and testbench

Parametrised successor to the fixed 8-bit UART top: full-duplex transmitter and receiver with configurable data width, bit period, stop-bit count and a receive FIFO.
- Sits between the system bus logic and the serial pins.
- Replaces the single-register receive path with a show-ahead FIFO that has overrun and framing-error reporting.
- Both directions share one clock domain.

---
 rtl/uart_param.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: TX FSM, RX FSM behind a 2-flop synchroniser, show-ahead receive FIFO.
// Optional parity bit (TX insert, RX check) is compiled in when UART_PARITY_EN is defined.
module uart_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  output logic                 uart_XMIT_dataH,
  input  logic                 xmitH,
  input  logic [DATA_BITS-1:0] xmit_dataH,
  output logic                 xmit_busyH,
  output logic                 xmit_doneH,
  input  logic                 uart_REC_dataH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 rec_readyH,
  input  logic                 rec_readH,
  output logic                 rec_overrunH,
  output logic                 rec_frame_errH,
  input  logic                 err_clrH
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_param: illegal parameter value");
  end

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_cnt_last;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_cnt_last = (tx_cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_last ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        tx_busy_d = 1'b0;
        if (xmitH) begin
          tx_shift_d = xmit_dataH;
          tx_busy_d  = 1'b1;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
`ifdef UART_PARITY_EN
          tx_par_d   = (^xmit_dataH) ^ 1'(PARITY_ODD);
`endif
        end
      end
      TX_START: if (tx_cnt_last) begin
        tx_bit_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_last) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_bit_d   = '0;
`ifdef UART_PARITY_EN
          tx_line_d  = tx_par_q;
          tx_state_d = TX_PARITY;
`else
          tx_line_d  = 1'b1;
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = tx_shift_q >> 1;
          tx_line_d  = tx_shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_cnt_last) begin
        tx_line_d  = 1'b1;
        tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tx_cnt_last) begin
        // Multi-stop frames reuse the bit counter to span STOP_BITS bit periods.
        if (tx_bit_q == STOP_LAST) begin
          tx_busy_d  = 1'b0;
          tx_done_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign uart_XMIT_dataH = tx_line_q;
  assign xmit_busyH      = tx_busy_q;
  assign xmit_doneH      = tx_done_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_cnt_last, rx_word_ok, rx_push, rx_frame_evt;
`ifdef UART_PARITY_EN
  logic                 rx_par_err_q, rx_par_err_d;

  assign rx_word_ok = rx_s2_q & ~rx_par_err_q;
`else
  assign rx_word_ok = rx_s2_q;
`endif

  assign rx_cnt_last = (rx_cnt_q == CNT_LAST);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_last ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_evt = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      // Half a bit in, the line must still be low or the edge was a glitch.
      RX_START: if (rx_cnt_q == CNT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_last) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_cnt_last) begin
        rx_par_err_d = ((^rx_shift_q) ^ rx_s2_q) != 1'(PARITY_ODD);
        rx_state_d   = RX_STOP;
      end
`endif
      RX_STOP: if (rx_cnt_last) begin
        if (rx_word_ok) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_frame_evt = 1'b1;
          rx_state_d   = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_state_q   <= RX_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
`ifdef UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q   <= rx_state_d;
      rx_s1_q      <= uart_REC_dataH;
      rx_s2_q      <= rx_s1_q;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
`ifdef UART_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic                 fifo_full, do_pop, do_push, overrun_evt;

  assign fifo_full   = (occ_q == OCC_FULL);
  assign do_pop      = rec_readH && (occ_q != '0);
  assign do_push     = rx_push && (!fifo_full || do_pop);
  assign overrun_evt = rx_push && fifo_full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    occ_d    = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    head_d   = head_q;
    // The head register tracks the word at rd_ptr; it holds its value once the FIFO drains.
    if (do_push && (occ_q == '0 || (do_pop && occ_q == OCC_ONE))) begin
      head_d = rx_shift_q;
    end else if (do_pop && occ_q > OCC_ONE) begin
      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
    end
    overrun_d   = overrun_evt  | (overrun_q   & ~err_clrH);
    frame_err_d = rx_frame_evt | (frame_err_q & ~err_clrH);
  end

  // NOTE: storage array has no reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rec_dataH      = head_q;
  assign rec_readyH     = (occ_q != '0);
  assign rec_overrunH   = overrun_q;
  assign rec_frame_errH = frame_err_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed self-checking bench for uart_param (default parameters; parity steps run when UART_PARITY_EN is defined).
module tb_uart_param;

  localparam int DATA_BITS    = 8;
  localparam int CLKS_PER_BIT = 16;
  localparam int STOP_BITS    = 1;
  localparam int FIFO_DEPTH   = 4;
  localparam int PARITY_ODD   = 0;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_l;
  logic                 uart_XMIT_dataH;
  logic                 xmitH;
  logic [DATA_BITS-1:0] xmit_dataH;
  logic                 xmit_busyH, xmit_doneH;
  logic                 uart_REC_dataH;
  logic [DATA_BITS-1:0] rec_dataH;
  logic                 rec_readyH, rec_readH;
  logic                 rec_overrunH, rec_frame_errH, err_clrH;
  logic                 loop_en, rx_drv;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  assign uart_REC_dataH = loop_en ? uart_XMIT_dataH : rx_drv;

  uart_param #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .STOP_BITS   (STOP_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_l      (sys_rst_l),
    .uart_XMIT_dataH(uart_XMIT_dataH),
    .xmitH          (xmitH),
    .xmit_dataH     (xmit_dataH),
    .xmit_busyH     (xmit_busyH),
    .xmit_doneH     (xmit_doneH),
    .uart_REC_dataH (uart_REC_dataH),
    .rec_dataH      (rec_dataH),
    .rec_readyH     (rec_readyH),
    .rec_readH      (rec_readH),
    .rec_overrunH   (rec_overrunH),
    .rec_frame_errH (rec_frame_errH),
    .err_clrH       (err_clrH)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (xmit_doneH !== 1'b1 && n < FRAME_CLKS + 20) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, xmit_doneH, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    xmitH      = 1'b1;
    xmit_dataH = d;
    tick();
    xmitH = 1'b0;
    wait_done(tag);
    tick();
  endtask

  task automatic pulse_clr();
    err_clrH = 1'b1;
    tick();
    err_clrH = 1'b0;
  endtask

  // Cycle-exact TX frame check: accept edge, mid-bit line values, busy/done timing, ignored request.
  task automatic tx_frame(input logic [7:0] d, input string tag);
    logic exp_bits [FRAME_BITS];
    int   bad = 0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) exp_bits[1 + i] = d[i];
`ifdef UART_PARITY_EN
    exp_bits[1 + DATA_BITS] = (^d) ^ 1'(PARITY_ODD);
`endif
    for (int i = 1 + DATA_BITS + PAR_BITS; i < FRAME_BITS; i++) exp_bits[i] = 1'b1;
    xmitH      = 1'b1;
    xmit_dataH = d;
    tick();
    xmitH      = 1'b0;
    xmit_dataH = ~d;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      if (c % CLKS_PER_BIT == CLKS_PER_BIT / 2)
        check($sformatf("%s_bit%0d", tag, c / CLKS_PER_BIT), uart_XMIT_dataH, exp_bits[c / CLKS_PER_BIT]);
      if (xmit_busyH !== 1'b1 || xmit_doneH !== 1'b0) bad++;
      xmitH = (c == 40);
      tick();
    end
    xmitH = 1'b0;
    check({tag, "_busy_through_frame"}, bad, 0);
    check({tag, "_done_at_end"}, xmit_doneH, 1'b1);
    check({tag, "_busy_drop"}, xmit_busyH, 1'b0);
    tick();
    check({tag, "_done_one_cycle"}, xmit_doneH, 1'b0);
    repeat (4) tick();
    check({tag, "_busy_req_not_queued"}, xmit_busyH, 1'b0);
    check({tag, "_line_idle"}, uart_XMIT_dataH, 1'b1);
  endtask

  // Bit-banged RX frame; par_flip inverts the correct parity bit when parity is compiled in.
  task automatic rx_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                          input logic chk_push, input string tag);
    rx_drv = 1'b0;
    repeat (CLKS_PER_BIT) tick();
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_drv = d[i];
      repeat (CLKS_PER_BIT) tick();
    end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ 1'(PARITY_ODD) ^ par_flip;
    repeat (CLKS_PER_BIT) tick();
`else
    if (par_flip) rx_drv = 1'b1;
`endif
    rx_drv = stop_bit;
    if (chk_push) check({tag, "_not_early"}, rec_readyH, 1'b0);
    repeat (CLKS_PER_BIT) tick();
    if (chk_push) begin
      check({tag, "_ready"}, rec_readyH, 1'b1);
      check({tag, "_data"}, rec_dataH, d);
    end
    rx_drv = 1'b1;
    repeat (CLKS_PER_BIT + 4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_l  = 1'b0;
    xmitH      = 1'b0;
    xmit_dataH = '0;
    rec_readH  = 1'b0;
    err_clrH   = 1'b0;
    loop_en    = 1'b0;
    rx_drv     = 1'b1;
    repeat (3) tick();
    check("rst_tx_line", uart_XMIT_dataH, 1'b1);
    check("rst_busy", xmit_busyH, 1'b0);
    check("rst_done", xmit_doneH, 1'b0);
    check("rst_ready", rec_readyH, 1'b0);
    check("rst_data", rec_dataH, 8'h00);
    check("rst_overrun", rec_overrunH, 1'b0);
    check("rst_frame_err", rec_frame_errH, 1'b0);
    sys_rst_l = 1'b1;
    repeat (3) tick();

    // TX frame shape and timing.
    tx_frame(8'hA5, "tx_a5");
`ifdef UART_PARITY_EN
    tx_frame(8'h07, "tx_07");
`endif

    // Loopback fill to full, then overrun.
    loop_en = 1'b1;
    send(8'h11, "lb11");
    send(8'h22, "lb22");
    send(8'h33, "lb33");
    send(8'h44, "lb44");
    check("full_ready", rec_readyH, 1'b1);
    check("full_head", rec_dataH, 8'h11);
    check("full_no_overrun", rec_overrunH, 1'b0);
    send(8'h55, "lb55");
    check("overrun_set", rec_overrunH, 1'b1);
    check("overrun_head_kept", rec_dataH, 8'h11);
    pulse_clr();
    check("overrun_clr", rec_overrunH, 1'b0);

    // Bad stop bit while the FIFO is full: word discarded, no overrun.
    loop_en = 1'b0;
    rx_frame(8'h3C, 1'b0, 1'b0, 1'b0, "ferr3c");
    check("ferr_set", rec_frame_errH, 1'b1);
    check("ferr_no_push_overrun", rec_overrunH, 1'b0);
    check("ferr_head_kept", rec_dataH, 8'h11);
    pulse_clr();
    check("ferr_clr", rec_frame_errH, 1'b0);

    // Drain the FIFO in order, then a pop on empty.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check($sformatf("pop%0d_data", i), rec_dataH, 8'h11 * (i + 1));
      rec_readH = 1'b1;
      tick();
      rec_readH = 1'b0;
    end
    check("drained_ready", rec_readyH, 1'b0);
    check("drained_data_held", rec_dataH, 8'h44);
    rec_readH = 1'b1;
    tick();
    rec_readH = 1'b0;
    check("empty_pop_ready", rec_readyH, 1'b0);
    check("empty_pop_data", rec_dataH, 8'h44);

    // Short low glitch is rejected; RX still receives a proper frame afterwards.
    rx_drv = 1'b0;
    repeat (6) tick();
    rx_drv = 1'b1;
    repeat (3 * CLKS_PER_BIT) tick();
    check("glitch_no_push", rec_readyH, 1'b0);
    check("glitch_no_ferr", rec_frame_errH, 1'b0);
    rx_frame(8'h96, 1'b1, 1'b0, 1'b1, "rx96");
    check("rx96_no_ferr", rec_frame_errH, 1'b0);

    // Reset in the middle of a looped frame.
    loop_en    = 1'b1;
    xmitH      = 1'b1;
    xmit_dataH = 8'hC3;
    tick();
    xmitH = 1'b0;
    repeat (50) tick();
    check("midframe_busy", xmit_busyH, 1'b1);
    sys_rst_l = 1'b0;
    #1;
    check("mid_rst_line", uart_XMIT_dataH, 1'b1);
    check("mid_rst_busy", xmit_busyH, 1'b0);
    check("mid_rst_done", xmit_doneH, 1'b0);
    check("mid_rst_ready", rec_readyH, 1'b0);
    check("mid_rst_data", rec_dataH, 8'h00);
    check("mid_rst_ferr", rec_frame_errH, 1'b0);
    check("mid_rst_overrun", rec_overrunH, 1'b0);
    repeat (3) tick();
    sys_rst_l = 1'b1;
    repeat (3) tick();
    send(8'h5A, "lb5a");
    check("post_rst_ready", rec_readyH, 1'b1);
    check("post_rst_data", rec_dataH, 8'h5A);
    check("post_rst_ferr", rec_frame_errH, 1'b0);

`ifdef UART_PARITY_EN
    // 0x07 has three ones, so even parity is 1; sending 0 must be flagged.
    loop_en = 1'b0;
    rx_frame(8'h07, 1'b1, 1'b1, 1'b0, "par07");
    check("par_err_set", rec_frame_errH, 1'b1);
    check("par_err_head_kept", rec_dataH, 8'h5A);
    rec_readH = 1'b1;
    tick();
    rec_readH = 1'b0;
    check("par_err_no_push", rec_readyH, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
